// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port word memory answering core accesses after WAIT_CYCLES wait states.
// Optional misalignment flagging is enabled by defining DMEM_MISALIGN_ERR_EN.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        re_we,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        valid,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT0 = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, mask_q, mask_d, acc_mask;
  logic we_q, we_d, acc_we;
  logic [AW+1:0] addr_q, addr_d, acc_addr;
  logic [31:0] data_q, data_d, acc_data, load_q, load_d, rd_word;
  logic valid_q, valid_d, err_q, err_d;
  logic idle, go_resp, mis, mem_we, unused_ok;
  logic [31:0] mem [DEPTH];
  assign idle = state_q == IDLE;
  // With zero wait states the access completes on the accepting edge, so the live inputs are used.
  assign acc_we   = idle ? re_we : we_q;
  assign acc_mask = idle ? mask : mask_q;
  assign acc_addr = idle ? address[AW+1:0] : addr_q;
  assign acc_data = idle ? store_data : data_q;
`ifdef DMEM_MISALIGN_ERR_EN
  assign mis = (acc_mask == 4'hf && acc_addr[1:0] != 2'd0) ||
               ((acc_mask == 4'h3 || acc_mask == 4'hc) && acc_addr[0]);
`else
  assign mis = 1'b0;
`endif
  assign unused_ok = ^{address[31:AW+2], acc_addr[1:0]};
  assign go_resp = (idle && request && WAIT_CYCLES == 0) || (state_q == WAIT && cnt_q == 4'd0);
  assign rd_word = mem[acc_addr[AW+1:2]];
  assign mem_we  = go_resp && acc_we && !mis && rst;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (idle && request) begin
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
      cnt_d   = CNT0;
      we_d    = re_we;
      mask_d  = mask;
      addr_d  = address[AW+1:0];
      data_d  = store_data;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    valid_d = go_resp;
    err_d   = go_resp && mis;
    load_d  = go_resp && (mis || !acc_we) ? (mis ? 32'd0 : rd_word) : load_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      mask_q  <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      load_q  <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  // Array contents survive reset; the rst term in mem_we blocks commits while reset is held.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && acc_mask[i]) mem[acc_addr[AW+1:2]][8*i +: 8] <= acc_data[8*i +: 8];
  end
  assign load_data = load_q;
  assign valid     = valid_q;
  assign err       = err_q;
endmodule
